// File: rtl/gray_conv_arbiter_pkg.sv
// Shared definitions for the Gray-conversion arbiter and other Gray-domain blocks:
// FSM state encoding and a generic binary-to-Gray helper.
package gray_conv_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCEPTED = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam int unsigned GRAY_MAX_W = 32;

  // Callers zero-extend narrower operands; the extra top zero bit leaves the low Gray bits unchanged.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request after last_grant,
// wrapping modulo N_REQ.
module rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    any_req   = |req;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one binary-to-Gray converter between N_REQ requesters with round-robin
// arbitration, one conversion in flight, and a saturating completion counter.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ  = 4,
  parameter  int unsigned DATA_W = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned IDX_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [IDX_W-1:0]        rsp_id,
  input  logic                    rsp_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        conv_count
);

  state_t             state;
  state_t             state_next;
  logic [N_REQ-1:0]   grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   id_reg;
  logic [DATA_W-1:0]  op_reg;
  logic               any_req;
  logic               accept;
  logic               complete;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req       (req_valid),
    .last_grant(last_grant),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  assign accept   = (state == IDLE) && any_req;
  assign complete = (state == HOLD) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (any_req) state_next = ACCEPTED;
      ACCEPTED: state_next = HOLD;
      HOLD:     if (rsp_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b0;
    if (state == IDLE) begin
      req_ready = grant;
    end else begin
      busy = 1'b1;
    end
  end

  // Only the granted slice is ever sampled, so X/Z on other slices cannot reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      id_reg     <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      if (accept) begin
        op_reg     <= req_data[grant_idx*DATA_W +: DATA_W];
        id_reg     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == ACCEPTED) begin
        rsp_data  <= DATA_W'(bin2gray(GRAY_MAX_W'(op_reg)));
        rsp_id    <= id_reg;
        rsp_valid <= 1'b1;
      end
      if (complete) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count <= '0;
    end else if (complete && (conv_count != '1)) begin
      conv_count <= conv_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench for gray_conv_arbiter: table-driven transactions with a response
// scoreboard, plus hand-written reset-in-HOLD and counter-saturation sequences.
module tb_gray_conv_arbiter;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] data;
    logic [1:0]  exp_id;
    logic [3:0]  exp_gray;
    int unsigned stall;
  } vec_t;

  typedef struct {
    logic [3:0] data;
    logic [1:0] id;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic        busy;
  logic [15:0] conv_count;

  logic [3:0]  s_valid;
  logic [15:0] s_data;
  logic [3:0]  s_req_ready;
  logic        s_rsp_valid;
  logic [3:0]  s_rsp_data;
  logic [1:0]  s_rsp_id;
  logic        s_ready;
  logic        s_busy;
  logic [1:0]  s_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [15:0] exp_cnt = '0;
  exp_t        sb[$];
  vec_t        vecs[$];
  logic [3:0]  gray_seq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                 4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  logic [1:0]  sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  gray_conv_arbiter #(
    .N_REQ (4),
    .DATA_W(4),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .conv_count(conv_count)
  );

  gray_conv_arbiter #(
    .N_REQ (4),
    .DATA_W(4),
    .CNT_W (2)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (s_valid),
    .req_data  (s_data),
    .req_ready (s_req_ready),
    .rsp_valid (s_rsp_valid),
    .rsp_data  (s_rsp_data),
    .rsp_id    (s_rsp_id),
    .rsp_ready (s_ready),
    .busy      (s_busy),
    .conv_count(s_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response handshake must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got response %0h id %0d expected none", rsp_data, rsp_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 32'(rsp_data), 32'(e.data));
        check("sb_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  task automatic run_txn(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.exp_id;
    req_valid = v.valid;
    req_data  = v.data;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("grant_ready", 32'(req_ready), 32'(oh));
    check("idle_busy", 32'(busy), 32'd0);
    sb.push_back('{data: v.exp_gray, id: v.exp_id});
    @(posedge clk); #1;
    check("acc_ready", 32'(req_ready), 32'd0);
    check("acc_valid", 32'(rsp_valid), 32'd0);
    check("acc_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("lat_valid", 32'(rsp_valid), 32'd1);
    for (int unsigned s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'(v.exp_gray));
      check("stall_id", 32'(rsp_id), 32'(v.exp_id));
      check("stall_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (exp_cnt != 16'hFFFF) exp_cnt++;
    check("count", 32'(conv_count), 32'(exp_cnt));
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    s_valid   = '0;
    s_data    = '0;
    s_ready   = 1'b0;

    vecs.push_back('{4'b0001, 16'h0006, 2'd0, 4'h5, 0});
    vecs.push_back('{4'b1000, 16'h5000, 2'd3, 4'h7, 0});
    vecs.push_back('{4'b1111, 16'h3C9A, 2'd0, 4'hF, 0});
    vecs.push_back('{4'b1111, 16'h3C9A, 2'd1, 4'hD, 0});
    vecs.push_back('{4'b1111, 16'h3C9A, 2'd2, 4'hA, 0});
    vecs.push_back('{4'b1111, 16'h3C9A, 2'd3, 4'h2, 0});
    vecs.push_back('{4'b1111, 16'h3C9A, 2'd0, 4'hF, 0});
    vecs.push_back('{4'b1111, 16'h3C9A, 2'd1, 4'hD, 0});
    vecs.push_back('{4'b0011, 16'h3C9A, 2'd0, 4'hF, 0});
    for (int x = 0; x < 16; x++) begin
      vecs.push_back('{4'b0100, 16'(x) << 8, 2'd2, gray_seq[x], (x % 4 == 3) ? 1 : 0});
    end
    vecs.push_back('{4'b0010, 16'hxxEx, 2'd1, 4'h9, 5});

    #2;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(conv_count), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i]);
    end
    req_valid = '0;
    @(posedge clk); #1;
    check("idle_after_table", 32'(busy), 32'd0);

    for (int k = 0; k < 5; k++) begin
      s_valid = 4'b0001;
      s_data  = 16'(k);
      @(posedge clk); #1;
      s_valid = '0;
      @(posedge clk); #1;
      s_ready = 1'b1;
      @(posedge clk); #1;
      s_ready = 1'b0;
      check("sat_count", 32'(s_count), 32'(sat_exp[k]));
    end

    // Asynchronous reset while a result is pending in HOLD.
    req_valid = 4'b0100;
    req_data  = 16'h0A00;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    check("rsthold_pre_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rsthold_valid", 32'(rsp_valid), 32'd0);
    check("rsthold_busy", 32'(busy), 32'd0);
    check("rsthold_count", 32'(conv_count), 32'd0);
    check("rsthold_data", 32'(rsp_data), 32'd0);
    sb.delete();
    exp_cnt = '0;
    req_valid = 4'b1111;
    req_data  = 16'h3C9A;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn('{4'b1111, 16'h3C9A, 2'd0, 4'hF, 0});
    req_valid = '0;
    @(posedge clk); #1;

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
